// File: rtl/uart_tx_sched_if.sv
// Buffer-side and transmitter-side signals of the UART transmit scheduler.
// The scheduler takes the master modport; the buffer/transmitter environment takes the slave one.
interface uart_tx_sched_if;
    logic [7:0] buf_data;
    logic       buf_valid;
    logic       buf_rd;
    logic [9:0] occupancy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  buf_data, buf_valid, occupancy, tx_ready,
        output buf_rd, tx_data, tx_valid
    );

    modport slave (
        output buf_data, buf_valid, occupancy, tx_ready,
        input  buf_rd, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Feeds a UART transmitter from a FWFT byte buffer and interleaves 4-byte status frames,
// arbitrating round-robin between the stream and status requesters.
module uart_tx_sched #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         STAT_PERIOD = 0,
    parameter int         GAP_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            stat_req,
    output logic            busy,
    output logic            stat_pending,
    output logic [15:0]     bytes_sent,
    output logic [15:0]     frames_sent,
    uart_tx_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        F_LOAD,
        F_SEND
    } state_e;

    state_e      state_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        buf_rd_q;
    logic        stat_pending_q;
    logic        stream_last_q;
    logic [15:0] bytes_sent_q;
    logic [15:0] frames_sent_q;
    logic [9:0]  occ_q;
    logic [1:0]  idx_q;
    logic [3:0]  gap_q;

    logic        auto_req;
    logic        stat_set;
    logic        tx_fire;
    logic [7:0]  frame_byte_d;

    assign tx_fire  = tx_valid_q & bus.tx_ready;
    assign stat_set = stat_req | auto_req;

    // Frame byte selected by the index; the checksum covers the three bytes before it.
    always_comb begin
        // NOTE: a default before the case keeps this block free of inferred latches.
        frame_byte_d = HEADER;
        unique case (idx_q)
            2'd0:    frame_byte_d = HEADER;
            2'd1:    frame_byte_d = {6'b0, occ_q[9:8]};
            2'd2:    frame_byte_d = occ_q[7:0];
            default: frame_byte_d = HEADER ^ {6'b0, occ_q[9:8]} ^ occ_q[7:0];
        endcase
    end

    generate
        if (STAT_PERIOD > 0) begin : g_timer
            localparam int            TW   = (STAT_PERIOD > 1) ? $clog2(STAT_PERIOD) : 1;
            localparam logic [TW-1:0] LAST = TW'(STAT_PERIOD - 1);

            logic [TW-1:0] timer_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer_q <= '0;
                end else if (timer_q == LAST) begin
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            assign auto_req = (timer_q == LAST);
        end else begin : g_no_timer
            assign auto_req = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
            buf_rd_q       <= 1'b0;
            stat_pending_q <= 1'b0;
            stream_last_q  <= 1'b1;
            bytes_sent_q   <= 16'h0000;
            frames_sent_q  <= 16'h0000;
            occ_q          <= 10'h000;
            idx_q          <= 2'd0;
            gap_q          <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            buf_rd_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (stat_pending_q && stream_last_q) begin
                            state_q       <= F_LOAD;
                            stream_last_q <= 1'b0;
                        end else if (bus.buf_valid) begin
                            state_q       <= S_LOAD;
                            buf_rd_q      <= 1'b1;
                            stream_last_q <= 1'b1;
                        end else if (stat_pending_q) begin
                            state_q       <= F_LOAD;
                            stream_last_q <= 1'b0;
                        end
                    end
                end

                // The head byte is still presented here; the pop takes effect on this edge.
                S_LOAD: begin
                    tx_data_q  <= bus.buf_data;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end

                S_SEND: begin
                    if (tx_fire) begin
                        tx_valid_q   <= 1'b0;
                        bytes_sent_q <= bytes_sent_q + 16'd1;
                        gap_q        <= 4'(GAP_CYCLES - 1);
                        state_q      <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end

                F_LOAD: begin
                    occ_q   <= bus.occupancy;
                    idx_q   <= 2'd0;
                    state_q <= F_SEND;
                end

                // tx_valid drops for one cycle after each transfer before the next byte is offered.
                F_SEND: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        if (idx_q == 2'd3) begin
                            frames_sent_q <= frames_sent_q + 16'd1;
                            state_q       <= IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else if (!tx_valid_q) begin
                        tx_data_q  <= frame_byte_d;
                        tx_valid_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase

            // Set is applied after clear so a request coinciding with F_LOAD is kept.
            if (state_q == F_LOAD) begin
                stat_pending_q <= 1'b0;
            end
            if (stat_set) begin
                stat_pending_q <= 1'b1;
            end
        end
    end

    assign bus.buf_rd   = buf_rd_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = (state_q != IDLE);
    assign stat_pending = stat_pending_q;
    assign bytes_sent   = bytes_sent_q;
    assign frames_sent  = frames_sent_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- HEADER, 8'hA5, first byte of a status frame.
- STAT_PERIOD, 0, cycles between automatic status requests; 0 disables them.
- GAP_CYCLES, 2, idle cycles after each buffer pop before buf_valid is sampled again; range 1..15.

REQ-002 The block SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock. Reset is asynchronous and active-high.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: permits new transfers to start.
- stat_req, in, 1: status frame request, one-cycle pulse.
- occupancy, in, 10: buffer fill level.
- buf_data, in, 8: buffer head byte, first-word-fall-through.
- buf_valid, in, 1: buf_data holds a valid head byte.
- buf_rd, out, 1: one-cycle pop of the buffer head.
- tx_data, out, 8: byte to the UART transmitter.
- tx_valid, out, 1: tx_data is offered.
- tx_ready, in, 1: transmitter can accept a byte.
- busy, out, 1: FSM is not in IDLE.
- stat_pending, out, 1: a status request is latched.
- bytes_sent, out, 16: count of stream bytes accepted by the transmitter.
- frames_sent, out, 16: count of completed status frames.

Function
REQ-003 A byte SHALL be transferred on a rising edge where tx_valid and tx_ready are both 1. tx_valid SHALL drop in the next cycle.
REQ-004 tx_data SHALL remain stable while tx_valid is 1. tx_valid SHALL NOT depend combinationally on tx_ready.
REQ-005 FSM states SHALL be IDLE, S_LOAD, S_SEND, S_GAP, F_LOAD and F_SEND.
REQ-006 In IDLE with enable=1:
- If stat_pending=1 and the last served requester was stream (or reset since), go to F_LOAD.
- Otherwise, if buf_valid=1, go to S_LOAD.
- Otherwise, if stat_pending=1, go to F_LOAD.
- This is round-robin between the status and stream requesters.
REQ-007 S_LOAD SHALL capture buf_data into a holding register and pulse buf_rd for exactly one cycle, then go to S_SEND.
REQ-008 S_SEND SHALL assert tx_valid with the held byte until it is transferred, then increment bytes_sent and go to S_GAP.
REQ-009 S_GAP SHALL wait GAP_CYCLES cycles, then return to IDLE.
REQ-010 F_LOAD SHALL snapshot occupancy into a register, clear stat_pending and set the byte index to 0, then go to F_SEND.
REQ-011 F_SEND SHALL send 4 bytes in order: HEADER; {6'b0, occ[9:8]}; occ[7:0]; XOR of the preceding three bytes.
REQ-012 After the fourth byte is transferred, frames_sent SHALL increment and the FSM SHALL return to IDLE.
REQ-013 Status frames SHALL be atomic. No stream byte is interleaved within a frame.
REQ-014 stat_pending SHALL set on a stat_req pulse or on auto-timer expiry, and SHALL clear only in F_LOAD.
- If a set and a clear coincide, set wins.
- Multiple requests while pending collapse into one.
REQ-015 If STAT_PERIOD>0, a free-running counter SHALL raise an internal request every STAT_PERIOD cycles, independent of enable.
REQ-016 enable=0 SHALL only block exits from IDLE. An in-flight byte or frame completes.
REQ-017 buf_rd SHALL never be asserted when buf_valid=0, nor outside S_LOAD.
REQ-018 bytes_sent and frames_sent SHALL wrap from 16'hFFFF to 0.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 While rst=1, all of the following SHALL hold asynchronously:
- State is IDLE.
- buf_rd=0, tx_valid=0, tx_data=0.
- stat_pending=0, busy=0.
- Both counters are 0, and the auto timer is 0.
- The round-robin pointer is set to stream-last, so a status frame wins the first tie.
REQ-021 A reset asserted mid-byte or mid-frame SHALL abort the transfer. No byte resumes after reset release.

Verification
REQ-022 Stream: buffer preloaded with 0x11, 0x22, 0x33; enable=1; tx_ready held 1 for one cycle per byte, re-asserted after 20 cycles
-> tx_data sequence 0x11, 0x22, 0x33; exactly 3 buf_rd pulses; bytes_sent=3; busy=0 at the end.
REQ-023 Status frame: occupancy=10'h2C5; stat_req pulse; buffer empty
-> bytes A5, 02, C5, 62; frames_sent=1; stat_pending=0.
REQ-024 Arbitration: buffer holds 4 bytes; stat_req pulsed before the first load
-> order is frame, byte, then the remaining bytes. A second stat_req during byte 2 yields a frame after byte 2.
REQ-025 Enable gating: enable deasserted while S_SEND waits for tx_ready
-> that byte completes; no further buf_rd while enable=0. Transfers resume on re-enable.
REQ-026 Reset mid-frame: rst pulsed after the second frame byte is transferred
-> tx_valid=0 immediately, counters 0. After release, no frame bytes are emitted without a new request.
REQ-027 Auto timer: STAT_PERIOD=100; stat_req tied 0; tx_ready always 1
-> frames start about every 100 cycles. Two timer expiries while pending collapse into one frame.
